// File: rtl/envelope_squelch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : envelope_squelch_pkg
// Brief    : Shared state encoding and counter widths for the envelope squelch.
// Revision : 1.0
// ============================================================================
package envelope_squelch_pkg;

    localparam int c_cnt_width   = 16;
    localparam int c_burst_width = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        HANG   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/envelope_squelch_oreg.sv
`default_nettype none
// ============================================================================
// Module   : envelope_squelch_oreg
// Brief    : One-deep AXI-stream output register (tdata/tlast, valid/ready).
// Revision : 1.0
// ============================================================================
module envelope_squelch_oreg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_accept,
    input  logic        i_emit,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_out_tready,
    output logic        o_in_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid
);

    logic [31:0] r_tdata;
    logic        r_tlast;
    logic        r_tvalid;

    assign o_in_tready = ~r_tvalid | i_out_tready;
    assign o_tdata     = r_tdata;
    assign o_tlast     = r_tlast;
    assign o_tvalid    = r_tvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (o_in_tready) begin
            r_tvalid <= i_accept & i_emit;
            if (i_accept & i_emit) begin
                r_tdata <= i_tdata;
                r_tlast <= i_tlast;
            end else begin
                r_tlast <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/envelope_squelch.sv
`default_nettype none
// ============================================================================
// Module   : envelope_squelch
// Brief    : Hysteresis squelch gating a magnitude stream into tlast-framed bursts.
// Revision : 1.0
// ============================================================================
module envelope_squelch
    import envelope_squelch_pkg::*;
#(
    parameter int MAG_WIDTH = 16,
    parameter int MAX_BURST = 2048
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [MAG_WIDTH-1:0]     thresh_on,
    input  logic [MAG_WIDTH-1:0]     thresh_off,
    input  logic [c_cnt_width-1:0]   attack_len,
    input  logic [c_cnt_width-1:0]   hang_len,
    input  logic [31:0]              i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [31:0]              o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     active,
    output logic [c_burst_width-1:0] burst_count
);

    localparam logic [c_cnt_width:0]   c_max_burst = (c_cnt_width+1)'(MAX_BURST);
    localparam logic [c_cnt_width-1:0] c_one       = (c_cnt_width)'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_cnt_width-1:0]   r_att_cnt;
    logic [c_cnt_width-1:0]   w_att_cnt_nxt;
    logic [c_cnt_width-1:0]   r_hang_cnt;
    logic [c_cnt_width-1:0]   w_hang_cnt_nxt;
    logic [c_cnt_width-1:0]   r_seg_cnt;
    logic [c_cnt_width-1:0]   w_seg_cnt_nxt;
    logic [c_burst_width-1:0] r_burst_count;
    logic [c_burst_width-1:0] w_burst_count_nxt;
    logic                     w_accept;
    logic                     w_emit;
    logic                     w_tlast;
    logic                     w_close;
    logic [MAG_WIDTH-1:0]     w_mag;
    logic [c_cnt_width-1:0]   w_att_target;
    logic [c_cnt_width:0]     w_att_inc;
    logic [c_cnt_width:0]     w_seg_inc;
    logic                     w_unused;

    assign w_mag        = i_tdata[MAG_WIDTH-1:0];
    assign w_accept     = i_tvalid & i_tready;
    assign w_att_target = (attack_len == '0) ? c_one : attack_len;
    assign w_att_inc    = {1'b0, r_att_cnt} + (c_cnt_width+1)'(1);
    assign w_seg_inc    = {1'b0, r_seg_cnt} + (c_cnt_width+1)'(1);
    assign w_unused     = i_tlast;
    assign active       = (r_state == ACTIVE) || (r_state == HANG);
    assign burst_count  = r_burst_count;

    always_comb begin
        w_state_nxt       = r_state;
        w_att_cnt_nxt     = r_att_cnt;
        w_hang_cnt_nxt    = r_hang_cnt;
        w_seg_cnt_nxt     = r_seg_cnt;
        w_burst_count_nxt = r_burst_count;
        w_emit            = 1'b0;
        w_tlast           = 1'b0;
        w_close           = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (enable && (w_mag >= thresh_on)) begin
                        if (w_att_target == c_one) begin
                            w_state_nxt   = ACTIVE;
                            w_att_cnt_nxt = '0;
                        end else begin
                            w_state_nxt   = ARM;
                            w_att_cnt_nxt = c_one;
                        end
                    end
                end
                ARM: begin
                    if (enable && (w_mag >= thresh_on)) begin
                        if (w_att_inc >= {1'b0, w_att_target}) begin
                            w_state_nxt   = ACTIVE;
                            w_att_cnt_nxt = '0;
                        end else begin
                            w_att_cnt_nxt = w_att_inc[c_cnt_width-1:0];
                        end
                    end else begin
                        w_state_nxt   = IDLE;
                        w_att_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_emit = 1'b1;
                    // The burst closes on the hang_len-th consecutive quiet beat;
                    // the beat that leaves ACTIVE counts as the first one.
                    if (!enable) begin
                        w_close = 1'b1;
                    end else if (w_mag >= thresh_off) begin
                        w_state_nxt = ACTIVE;
                    end else if (r_state == ACTIVE) begin
                        if (hang_len <= c_one) begin
                            w_close = 1'b1;
                        end else begin
                            w_hang_cnt_nxt = hang_len - c_one;
                            w_state_nxt    = HANG;
                        end
                    end else if (r_hang_cnt <= c_one) begin
                        w_close = 1'b1;
                    end else begin
                        w_hang_cnt_nxt = r_hang_cnt - c_one;
                    end

                    if (w_close) begin
                        w_tlast           = 1'b1;
                        w_state_nxt       = IDLE;
                        w_hang_cnt_nxt    = '0;
                        w_seg_cnt_nxt     = '0;
                        w_burst_count_nxt = r_burst_count + 1'b1;
                    end else if (w_seg_inc == c_max_burst) begin
                        w_tlast       = 1'b1;
                        w_seg_cnt_nxt = '0;
                    end else begin
                        w_seg_cnt_nxt = w_seg_inc[c_cnt_width-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_att_cnt     <= '0;
            r_hang_cnt    <= '0;
            r_seg_cnt     <= '0;
            r_burst_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_att_cnt     <= w_att_cnt_nxt;
            r_hang_cnt    <= w_hang_cnt_nxt;
            r_seg_cnt     <= w_seg_cnt_nxt;
            r_burst_count <= w_burst_count_nxt;
        end
    end

    envelope_squelch_oreg u_oreg (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_accept     (w_accept),
        .i_emit       (w_emit),
        .i_tdata      (i_tdata),
        .i_tlast      (w_tlast),
        .i_out_tready (o_tready),
        .o_in_tready  (i_tready),
        .o_tdata      (o_tdata),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid)
    );

endmodule
`default_nettype wire
